// File: rtl/regfile_writeback_queue.sv
// In-order write-back queue that feeds the register file write port from the ALU and load paths.
// Define WBQ_FORWARDING_EN to drive fwd_valid/fwd_data from the youngest pending write.
module regfile_writeback_queue #(
  parameter int DEPTH          = 4,
  parameter int PROTECTED_ADDR = 28
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [4:0]             alu_address,
  input  logic [31:0]            alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [4:0]             mem_address,
  input  logic [31:0]            mem_data,
  input  logic [4:0]             readAddress1,
  input  logic [4:0]             readAddress2,
  output logic                   writeRegister,
  output logic [4:0]             writeAddress,
  output logic [31:0]            writeData,
  output logic                   hazard1,
  output logic                   hazard2,
  output logic                   fwd_valid1,
  output logic [31:0]            fwd_data1,
  output logic                   fwd_valid2,
  output logic [31:0]            fwd_data2,
  output logic                   dropped,
  output logic [$clog2(DEPTH):0] count,
  output logic                   idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [4:0]    PROT_ADDR  = 5'(PROTECTED_ADDR);

  logic [4:0]    entryAddr_q [DEPTH];
  logic [31:0]   entryData_q [DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;
  logic          writeRegister_q, dropped_q;
  logic [4:0]    writeAddress_q;
  logic [31:0]   writeData_q;

  logic          notFull, accept, isProtected, doPush, doPop;
  logic [4:0]    pushAddr;
  logic [31:0]   pushData;
  logic [PW-1:0] hazIdx;

  assign notFull     = count_q < FULL_COUNT;
  assign mem_ready   = notFull;
  assign alu_ready   = notFull && !mem_valid;
  assign accept      = notFull && (mem_valid || alu_valid);
  assign pushAddr    = mem_valid ? mem_address : alu_address;
  assign pushData    = mem_valid ? mem_data : alu_data;
  assign isProtected = pushAddr == PROT_ADDR;
  assign doPush      = accept && !isProtected;
  assign doPop       = count_q != '0;
  assign count_d     = count_q + CW'(doPush) - CW'(doPop);

  // Storage needs no reset: only entries inside the occupancy window are ever looked at.
  always_ff @(posedge clock) begin
    if (doPush) begin
      entryAddr_q[wrPtr_q] <= pushAddr;
      entryData_q[wrPtr_q] <= pushData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q         <= '0;
      rdPtr_q         <= '0;
      count_q         <= '0;
      writeRegister_q <= 1'b0;
      writeAddress_q  <= '0;
      writeData_q     <= '0;
      dropped_q       <= 1'b0;
    end else begin
      count_q         <= count_d;
      dropped_q       <= accept && isProtected;
      writeRegister_q <= doPop;
      if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
      if (doPop) begin
        rdPtr_q        <= rdPtr_q + PW'(1);
        writeAddress_q <= entryAddr_q[rdPtr_q];
        writeData_q    <= entryData_q[rdPtr_q];
      end
    end
  end

  // The uncommitted register-file write counts as pending alongside the queued entries.
  always_comb begin
    hazard1 = writeRegister_q && (writeAddress_q == readAddress1);
    hazard2 = writeRegister_q && (writeAddress_q == readAddress2);
    hazIdx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        hazIdx = rdPtr_q + PW'(k);
        if (entryAddr_q[hazIdx] == readAddress1) hazard1 = 1'b1;
        if (entryAddr_q[hazIdx] == readAddress2) hazard2 = 1'b1;
      end
    end
  end

`ifdef WBQ_FORWARDING_EN
  logic [PW-1:0] fwdIdx;
  logic [31:0]   fwdData1, fwdData2;

  // Walk oldest to youngest so the last match (youngest write) wins.
  always_comb begin
    fwdData1 = writeData_q;
    fwdData2 = writeData_q;
    fwdIdx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        fwdIdx = rdPtr_q + PW'(k);
        if (entryAddr_q[fwdIdx] == readAddress1) fwdData1 = entryData_q[fwdIdx];
        if (entryAddr_q[fwdIdx] == readAddress2) fwdData2 = entryData_q[fwdIdx];
      end
    end
  end

  assign fwd_valid1 = hazard1;
  assign fwd_valid2 = hazard2;
  assign fwd_data1  = hazard1 ? fwdData1 : '0;
  assign fwd_data2  = hazard2 ? fwdData2 : '0;
`else
  assign fwd_valid1 = 1'b0;
  assign fwd_valid2 = 1'b0;
  assign fwd_data1  = '0;
  assign fwd_data2  = '0;
`endif

  assign writeRegister = writeRegister_q;
  assign writeAddress  = writeAddress_q;
  assign writeData     = writeData_q;
  assign dropped       = dropped_q;
  assign count         = count_q;
  assign idle          = (count_q == '0) && !writeRegister_q;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue; register-file writes are checked against a scoreboard queue.
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_address, mem_address;
  logic [31:0] alu_data, mem_data;
  logic [4:0]  readAddress1, readAddress2;
  logic        writeRegister;
  logic [4:0]  writeAddress;
  logic [31:0] writeData;
  logic        hazard1, hazard2;
  logic        fwd_valid1, fwd_valid2;
  logic [31:0] fwd_data1, fwd_data2;
  logic        dropped;
  logic [2:0]  count;
  logic        idle;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t expQ[$];
  wr_t expWr;
  int  vectors = 0;
  int  miscompares = 0;
  int  writesSeen = 0;
  int  writesBefore;

  regfile_writeback_queue #(.DEPTH(DEPTH), .PROTECTED_ADDR(28)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_address(alu_address), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_address(mem_address), .mem_data(mem_data),
    .readAddress1(readAddress1), .readAddress2(readAddress2),
    .writeRegister(writeRegister), .writeAddress(writeAddress), .writeData(writeData),
    .hazard1(hazard1), .hazard2(hazard2),
    .fwd_valid1(fwd_valid1), .fwd_data1(fwd_data1), .fwd_valid2(fwd_valid2), .fwd_data2(fwd_data2),
    .dropped(dropped), .count(count), .idle(idle)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run one unit later.
  task automatic applyStimulus(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                               input logic av, input logic [4:0] aa, input logic [31:0] ad);
    @(posedge clock);
    #1;
    mem_valid = mv; mem_address = ma; mem_data = md;
    alu_valid = av; alu_address = aa; alu_data = ad;
    #1;
  endtask

  // Scoreboard: compare any write first, then record the handshake that completes at the next edge.
  always @(negedge clock) begin
    if (reset) begin
      expQ.delete();
    end else begin
      if (writeRegister) begin
        checkOutput("writeExpected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          expWr = expQ.pop_front();
          checkOutput("sbWriteAddress", 32'(writeAddress), 32'(expWr.addr));
          checkOutput("sbWriteData", writeData, expWr.data);
        end
        writesSeen++;
      end
      if (mem_valid && mem_ready) begin
        if (mem_address != 5'd28) expQ.push_back({mem_address, mem_data});
      end else if (alu_valid && alu_ready) begin
        if (alu_address != 5'd28) expQ.push_back({alu_address, alu_data});
      end
    end
  end

  initial begin
    reset = 1'b1;
    mem_valid = 0; mem_address = 0; mem_data = 0;
    alu_valid = 0; alu_address = 0; alu_data = 0;
    readAddress1 = 5'd31; readAddress2 = 5'd30;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checkOutput("resetCount", 32'(count), 0);
    checkOutput("resetWriteRegister", 32'(writeRegister), 0);
    checkOutput("resetWriteAddress", 32'(writeAddress), 0);
    checkOutput("resetWriteData", writeData, 0);
    checkOutput("resetDropped", 32'(dropped), 0);
    checkOutput("resetIdle", 32'(idle), 1);

    // Single ALU write and its one-cycle latency.
    applyStimulus(0, 0, 0, 1, 5'd5, 32'h1234);
    checkOutput("t1AluReady", 32'(alu_ready), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t1CountQueued", 32'(count), 1);
    checkOutput("t1NotYetWritten", 32'(writeRegister), 0);
    checkOutput("t1IdleBusy", 32'(idle), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t1WriteRegister", 32'(writeRegister), 1);
    checkOutput("t1WriteAddress", 32'(writeAddress), 5);
    checkOutput("t1WriteData", writeData, 32'h1234);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t1WriteDone", 32'(writeRegister), 0);
    checkOutput("t1Idle", 32'(idle), 1);
    checkOutput("t1AddressHeld", 32'(writeAddress), 5);

    // Contention: mem wins, alu follows.
    applyStimulus(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
    checkOutput("t2MemReady", 32'(mem_ready), 1);
    checkOutput("t2AluBlocked", 32'(alu_ready), 0);
    applyStimulus(0, 0, 0, 1, 5'd4, 32'h44);
    checkOutput("t2AluReady", 32'(alu_ready), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t2FirstAddress", 32'(writeAddress), 3);
    checkOutput("t2FirstData", writeData, 32'h33);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t2SecondAddress", 32'(writeAddress), 4);
    checkOutput("t2SecondWrite", 32'(writeRegister), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t2Drained", 32'(writeRegister), 0);

    // Back-to-back mem pushes: drain keeps pace, so occupancy stays at one.
    writesBefore = writesSeen;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 5'(10 + i), 32'h100 + 32'(i), 0, 0, 0);
      checkOutput("t3MemReady", 32'(mem_ready), 1);
      checkOutput("t3Count", 32'(count), (i == 0) ? 0 : 1);
    end
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t3AllWritten", 32'(writesSeen - writesBefore), 5);
    checkOutput("t3ScoreboardEmpty", 32'(expQ.size()), 0);
    checkOutput("t3Idle", 32'(idle), 1);

    // Protected address is handshaken and discarded.
    applyStimulus(1, 5'd28, 32'hFFFF, 0, 0, 0);
    checkOutput("t4MemReady", 32'(mem_ready), 1);
    checkOutput("t4NoDropYet", 32'(dropped), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t4Dropped", 32'(dropped), 1);
    checkOutput("t4Count", 32'(count), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t4DropPulse", 32'(dropped), 0);
    checkOutput("t4NoWrite", 32'(writeRegister), 0);

    // Hazards and forwarding on two writes to r7.
    readAddress1 = 5'd7; readAddress2 = 5'd8;
    applyStimulus(0, 0, 0, 1, 5'd7, 32'hA);
    checkOutput("t5PushNotHazard", 32'(hazard1), 0);
    applyStimulus(0, 0, 0, 1, 5'd7, 32'hB);
    checkOutput("t5HazardQueued", 32'(hazard1), 1);
    checkOutput("t5Hazard2Clear", 32'(hazard2), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t5HazardBoth", 32'(hazard1), 1);
`ifdef WBQ_FORWARDING_EN
    checkOutput("t5FwdValid", 32'(fwd_valid1), 1);
    checkOutput("t5FwdYoungest", fwd_data1, 32'hB);
    checkOutput("t5Fwd2Valid", 32'(fwd_valid2), 0);
`else
    checkOutput("t5FwdValidOff", 32'(fwd_valid1), 0);
    checkOutput("t5FwdDataOff", fwd_data1, 0);
`endif
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t5HazardWriting", 32'(hazard1), 1);
    checkOutput("t5WriteB", writeData, 32'hB);
`ifdef WBQ_FORWARDING_EN
    checkOutput("t5FwdFromWrite", fwd_data1, 32'hB);
`endif
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t5HazardCleared", 32'(hazard1), 0);
    checkOutput("t5FwdCleared", 32'(fwd_valid1), 0);

    // Reset while writes are still pending, including one to r0.
    readAddress1 = 5'd20; readAddress2 = 5'd0;
    applyStimulus(1, 5'd20, 32'h2020, 0, 0, 0);
    applyStimulus(1, 5'd21, 32'h2121, 0, 0, 0);
    applyStimulus(1, 5'd0, 32'hABCD, 0, 0, 0);
    checkOutput("t6HazardWriting", 32'(hazard1), 1);
    checkOutput("t6Hazard2Clear", 32'(hazard2), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t6HazardR0", 32'(hazard2), 1);
    checkOutput("t6Hazard1Gone", 32'(hazard1), 0);
    checkOutput("t6CountBefore", 32'(count), 1);
    reset = 1'b1;
    #1;
    checkOutput("t6ResetCount", 32'(count), 0);
    checkOutput("t6ResetWrite", 32'(writeRegister), 0);
    checkOutput("t6ResetHazard1", 32'(hazard1), 0);
    checkOutput("t6ResetHazard2", 32'(hazard2), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    writesBefore = writesSeen;
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t6NoWritesAfter", 32'(writesSeen - writesBefore), 0);
    checkOutput("t6Idle", 32'(idle), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
